// File: rtl/spi_target_regfile.sv
// SPI mode-0 target giving an external host byte access to a small register file shared with a local port.
// All SPI pins are oversampled in soc_clk; the frame is a command byte followed by auto-incrementing data bytes.
module spi_target_regfile #(
  parameter int NumRegs    = 16,
  parameter int AddrWidth  = $clog2(NumRegs),
  parameter int SyncStages = 2
) (
  input  logic                 soc_clk,
  input  logic                 rst_n,
  input  logic                 spi_sck_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_en_o,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic                 reg_we_i,
  input  logic [7:0]           reg_wdata_i,
  output logic [7:0]           reg_rdata_o,
  output logic                 host_wr_o,
  output logic [AddrWidth-1:0] host_wr_addr_o,
  output logic                 frame_active_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SyncStages-1:0] sck_sync, csb_sync, mosi_sync;
  logic                  sck_q, csb_q;
  logic                  sck_s, csb_s, mosi_s;
  logic                  sck_rise, sck_fall, csb_fall;

  logic [1:0]           state;
  logic [2:0]           bit_cnt;
  logic [6:0]           rx;
  logic [7:0]           rx_byte;
  logic [7:0]           tx;
  logic [AddrWidth-1:0] addr, addr_nxt, cmd_addr;
  logic                 rw;
  logic [7:0]           mem [NumRegs];

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      csb_sync  <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      csb_q     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
      csb_sync  <= {csb_sync[SyncStages-2:0], spi_csb_i};
      mosi_sync <= {mosi_sync[SyncStages-2:0], spi_mosi_i};
      sck_q     <= sck_s;
      csb_q     <= csb_s;
    end
  end

  assign sck_s    = sck_sync[SyncStages-1];
  assign csb_s    = csb_sync[SyncStages-1];
  assign mosi_s   = mosi_sync[SyncStages-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign csb_fall = ~csb_s & csb_q;

  assign rx_byte  = {rx, mosi_s};
  assign cmd_addr = rx_byte[AddrWidth-1:0];
  assign addr_nxt = addr + AddrWidth'(1);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bit_cnt        <= 3'd0;
      rx             <= 7'd0;
      tx             <= 8'd0;
      addr           <= '0;
      rw             <= 1'b0;
      spi_miso_o     <= 1'b0;
      spi_miso_en_o  <= 1'b0;
      frame_active_o <= 1'b0;
      host_wr_o      <= 1'b0;
      host_wr_addr_o <= '0;
      reg_rdata_o    <= 8'd0;
      for (int i = 0; i < NumRegs; i++) mem[i] <= 8'd0;
    end else begin
      host_wr_o   <= 1'b0;
      reg_rdata_o <= mem[reg_addr_i];
      // Local write is issued first so a same-cycle SPI commit overrides it.
      if (reg_we_i) mem[reg_addr_i] <= reg_wdata_i;

      case (state)
        ST_IDLE: begin
          if (csb_fall) begin
            state          <= ST_CMD;
            bit_cnt        <= 3'd0;
            spi_miso_en_o  <= 1'b1;
            frame_active_o <= 1'b1;
          end
        end
        ST_CMD, ST_DATA: begin
          // CSB release wins over any SCK edge seen in the same cycle; partial byte dropped.
          if (csb_s) begin
            state          <= ST_IDLE;
            bit_cnt        <= 3'd0;
            spi_miso_o     <= 1'b0;
            spi_miso_en_o  <= 1'b0;
            frame_active_o <= 1'b0;
          end else if (sck_rise) begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_CMD) begin
                rw    <= rx_byte[7];
                addr  <= cmd_addr;
                state <= ST_DATA;
                if (rx_byte[7]) tx <= mem[cmd_addr];
              end else if (rw) begin
                addr <= addr_nxt;
                tx   <= mem[addr_nxt];
              end else begin
                mem[addr]      <= rx_byte;
                host_wr_o      <= 1'b1;
                host_wr_addr_o <= addr;
                addr           <= addr_nxt;
              end
            end
          end else if (sck_fall && state == ST_DATA && rw) begin
            spi_miso_o <= tx[7];
            tx         <= {tx[6:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_regfile.sv
// Bench for spi_target_regfile: randomized SPI frames and local accesses against an array model,
// with scoreboard queues popped by monitors on MISO bytes, host write pulses and local reads.
module tb_spi_target_regfile;

  logic       soc_clk = 1'b0;
  logic       rst_n;
  logic       sck, csb, mosi;
  logic       spi_miso_o, spi_miso_en_o;
  logic [3:0] reg_addr;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata_o;
  logic       host_wr_o;
  logic [3:0] host_wr_addr_o;
  logic       frame_active_o;

  spi_target_regfile #(.NumRegs(16), .SyncStages(2)) dut (
    .soc_clk        (soc_clk),
    .rst_n          (rst_n),
    .spi_sck_i      (sck),
    .spi_csb_i      (csb),
    .spi_mosi_i     (mosi),
    .spi_miso_o     (spi_miso_o),
    .spi_miso_en_o  (spi_miso_en_o),
    .reg_addr_i     (reg_addr),
    .reg_we_i       (reg_we),
    .reg_wdata_i    (reg_wdata),
    .reg_rdata_o    (reg_rdata_o),
    .host_wr_o      (host_wr_o),
    .host_wr_addr_o (host_wr_addr_o),
    .frame_active_o (frame_active_o)
  );

  always #5 soc_clk = ~soc_clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mdl [16];
  logic [7:0] miso_q [$];
  logic [7:0] rd_q [$];
  int         wr_q [$];

  logic       rd_req = 1'b0;
  logic       rd_req_q = 1'b0;
  int         mbits = 0;
  logic [7:0] mbyte = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MISO monitor: the host samples on its own rising SCK edge.
  always @(posedge sck or posedge csb or negedge rst_n) begin
    if (csb || !rst_n) begin
      mbits = 0;
    end else begin
      mbyte = {mbyte[6:0], spi_miso_o};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        chk("miso_en_in_frame", spi_miso_en_o, 1);
        if (miso_q.size() == 0) chk("miso_unexpected_byte", 1, 0);
        else chk("miso_byte", mbyte, miso_q.pop_front());
      end
    end
  end

  always @(negedge soc_clk) begin
    if (rst_n && host_wr_o) begin
      if (wr_q.size() == 0) chk("host_wr_unexpected", 1, 0);
      else chk("host_wr_addr", host_wr_addr_o, wr_q.pop_front());
    end
  end

  always @(posedge soc_clk) rd_req_q <= rd_req;

  always @(negedge soc_clk) begin
    if (rd_req_q) begin
      if (rd_q.size() == 0) chk("local_rd_unexpected", 1, 0);
      else chk("local_rdata", reg_rdata_o, rd_q.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, spi_miso_o, 0);
    chk({tag, "_miso_en"}, spi_miso_en_o, 0);
    chk({tag, "_rdata"}, reg_rdata_o, 0);
    chk({tag, "_host_wr"}, host_wr_o, 0);
    chk({tag, "_host_wr_addr"}, host_wr_addr_o, 0);
    chk({tag, "_frame_active"}, frame_active_o, 0);
  endtask

  task automatic cs_low();
    @(negedge soc_clk);
    csb = 1'b0;
    repeat (6) @(negedge soc_clk);
    chk("frame_active_on", frame_active_o, 1);
    chk("miso_en_on", spi_miso_en_o, 1);
  endtask

  task automatic cs_high();
    repeat (6) @(negedge soc_clk);
    csb = 1'b1;
    repeat (6) @(negedge soc_clk);
    chk("frame_active_off", frame_active_o, 0);
    chk("miso_en_off", spi_miso_en_o, 0);
    chk("miso_idle", spi_miso_o, 0);
  endtask

  // One byte at f_soc/10; optional local write timed onto the DUT's 8th-edge commit cycle.
  task automatic spi_byte(input logic [7:0] d, input logic [7:0] exp, input int nbits,
                          input bit coll, input logic [3:0] caddr, input logic [7:0] cdat);
    if (nbits == 8) miso_q.push_back(exp);
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      repeat (5) @(negedge soc_clk);
      sck = 1'b1;
      if (coll && i == 7) begin
        repeat (2) @(negedge soc_clk);
        reg_addr  = caddr;
        reg_wdata = cdat;
        reg_we    = 1'b1;
        @(negedge soc_clk);
        reg_we = 1'b0;
        repeat (2) @(negedge soc_clk);
      end else begin
        repeat (5) @(negedge soc_clk);
      end
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int n, input logic [7:0] d0,
                           input logic [7:0] d1, input bit rnd);
    int         a;
    logic [7:0] d;
    cs_low();
    spi_byte(cmd, 8'h00, 8, 1'b0, 4'd0, 8'd0);
    a = int'(cmd[3:0]);
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : (i == 0 ? d0 : d1);
      if (cmd[7]) begin
        spi_byte(d, mdl[a], 8, 1'b0, 4'd0, 8'd0);
      end else begin
        wr_q.push_back(a);
        mdl[a] = d;
        spi_byte(d, 8'h00, 8, 1'b0, 4'd0, 8'd0);
      end
      a = (a + 1) % 16;
    end
    cs_high();
  endtask

  task automatic local_wr(input int a, input logic [7:0] d);
    @(negedge soc_clk);
    reg_addr  = 4'(a);
    reg_wdata = d;
    reg_we    = 1'b1;
    @(negedge soc_clk);
    reg_we  = 1'b0;
    mdl[a]  = d;
  endtask

  task automatic local_rd(input int a);
    @(negedge soc_clk);
    reg_addr = 4'(a);
    rd_req   = 1'b1;
    rd_q.push_back(mdl[a]);
    @(negedge soc_clk);
    rd_req = 1'b0;
    @(negedge soc_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sck = 1'b0; csb = 1'b1; mosi = 1'b0;
    reg_addr = 4'd0; reg_we = 1'b0; reg_wdata = 8'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    repeat (3) @(negedge soc_clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge soc_clk);

    // Write frame 0x03, 0xA5, 0x5A
    spi_frame(8'h03, 2, 8'hA5, 8'h5A, 1'b0);
    local_rd(4);
    local_rd(3);

    // Read wrap 15 -> 0
    local_wr(15, 8'h11);
    local_wr(0, 8'h22);
    spi_frame(8'h8F, 2, 8'h00, 8'h00, 1'b0);

    // Abort after 5 data bits: nothing committed, next frame fine
    cs_low();
    spi_byte(8'h05, 8'h00, 8, 1'b0, 4'd0, 8'd0);
    spi_byte(8'hFF, 8'h00, 5, 1'b0, 4'd0, 8'd0);
    cs_high();
    local_rd(5);
    spi_frame(8'h06, 1, 8'h3C, 8'h00, 1'b0);
    local_rd(6);

    // Same-cycle local write 0x33 vs SPI commit 0x44 at addr 2
    cs_low();
    spi_byte(8'h02, 8'h00, 8, 1'b0, 4'd0, 8'd0);
    wr_q.push_back(2);
    spi_byte(8'h44, 8'h00, 8, 1'b1, 4'd2, 8'h33);
    mdl[2] = 8'h44;
    cs_high();
    local_rd(2);

    // Local write to the byte already loaded for shifting does not disturb it
    local_wr(9, 8'h99);
    cs_low();
    spi_byte(8'h89, 8'h00, 8, 1'b0, 4'd0, 8'd0);
    local_wr(9, 8'hAB);
    spi_byte(8'h00, 8'h99, 8, 1'b0, 4'd0, 8'd0);
    cs_high();
    local_rd(9);

    // Reset mid read frame at addr 7
    local_wr(7, 8'h77);
    cs_low();
    spi_byte(8'h87, 8'h00, 8, 1'b0, 4'd0, 8'd0);
    spi_byte(8'h00, 8'h00, 3, 1'b0, 4'd0, 8'd0);
    @(negedge soc_clk);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    repeat (2) @(negedge soc_clk);
    check_reset_outputs("midframe_reset");
    csb = 1'b1;
    repeat (3) @(negedge soc_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge soc_clk);
    local_rd(7);
    spi_frame(8'h87, 1, 8'h00, 8'h00, 1'b0);

    // Command address taken modulo NumRegs
    local_wr(3, 8'hC7);
    spi_frame(8'h93, 1, 8'h00, 8'h00, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      int nlw;
      nlw = $urandom_range(0, 2);
      for (int k = 0; k < nlw; k++) local_wr($urandom_range(0, 15), 8'($urandom));
      spi_frame(8'($urandom), $urandom_range(1, 3), 8'h00, 8'h00, 1'b1);
      if (it % 3 == 0) local_rd($urandom_range(0, 15));
    end
    for (int a = 0; a < 16; a++) local_rd(a);

    repeat (20) @(negedge soc_clk);
    chk("miso_q_drained", miso_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
